// File: rtl/ram4k_rr_ctrl.sv
// Two-port round-robin controller sequencing a single RAM4K (4096 x 16).
// Optional grant counters gnt_cnt0/gnt_cnt1 when RAMCTL_STATS_EN is defined.
module ram4k_rr_ctrl #(
   parameter int unsigned AW = 12,
   parameter int unsigned DW = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic          ack1,
   output logic [DW-1:0] rdata0,
   output logic [DW-1:0] rdata1,
   output logic          busy,
   output logic          ram_e,
   output logic [AW-1:0] ram_addr,
   output logic [DW-1:0] ram_din,
   output logic          ram_w,
   output logic          ram_r,
   input  logic [DW-1:0] ram_dout
`ifdef RAMCTL_STATS_EN
   ,
   output logic [15:0]   gnt_cnt0,
   output logic [15:0]   gnt_cnt1
`endif
);

   typedef enum logic [1:0] {IDLE, A1, A2, RESP} state_t;

   state_t        state_q, state_d;
   logic          ptr_q, ptr_d;
   logic          id_q, id_d;
   logic          we_q, we_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic          ram_e_q, ram_e_d;
   logic          ram_w_q, ram_w_d;
   logic          ram_r_q, ram_r_d;
   logic          ack0_q, ack0_d;
   logic          ack1_q, ack1_d;
   logic [DW-1:0] rdata0_q, rdata0_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic          busy_q, busy_d;
   logic          gnt;
   logic          gnt_we;
`ifdef RAMCTL_STATS_EN
   logic [15:0]   gnt_cnt0_q, gnt_cnt0_d;
   logic [15:0]   gnt_cnt1_q, gnt_cnt1_d;
`endif

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      id_d     = id_q;
      we_d     = we_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      ram_e_d  = ram_e_q;
      ram_w_d  = ram_w_q;
      ram_r_d  = ram_r_q;
      ack0_d   = 1'b0;
      ack1_d   = 1'b0;
      rdata0_d = rdata0_q;
      rdata1_d = rdata1_q;
      busy_d   = busy_q;
      // A tie goes to ptr; a lone requester always wins.
      gnt      = (req0 & req1) ? ptr_q : req1;
      gnt_we   = gnt ? we1 : we0;
`ifdef RAMCTL_STATS_EN
      gnt_cnt0_d = gnt_cnt0_q;
      gnt_cnt1_d = gnt_cnt1_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               state_d = A1;
               id_d    = gnt;
               we_d    = gnt_we;
               addr_d  = gnt ? addr1 : addr0;
               wdata_d = gnt ? wdata1 : wdata0;
               ram_e_d = 1'b1;
               ram_w_d = gnt_we;
               ram_r_d = ~gnt_we;
               busy_d  = 1'b1;
            end
         end
         A1: state_d = A2;
         A2: begin
            state_d = RESP;
            ram_e_d = 1'b0;
            ram_w_d = 1'b0;
            ram_r_d = 1'b0;
            if (!we_q) begin
               if (id_q) rdata1_d = ram_dout;
               else      rdata0_d = ram_dout;
            end
            ack0_d = ~id_q;
            ack1_d = id_q;
         end
         RESP: begin
            state_d = IDLE;
            busy_d  = 1'b0;
            ptr_d   = ~id_q;
`ifdef RAMCTL_STATS_EN
            if (id_q) gnt_cnt1_d = gnt_cnt1_q + 16'd1;
            else      gnt_cnt0_d = gnt_cnt0_q + 16'd1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         id_q     <= 1'b0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         ram_e_q  <= 1'b0;
         ram_w_q  <= 1'b0;
         ram_r_q  <= 1'b0;
         ack0_q   <= 1'b0;
         ack1_q   <= 1'b0;
         rdata0_q <= '0;
         rdata1_q <= '0;
         busy_q   <= 1'b0;
`ifdef RAMCTL_STATS_EN
         gnt_cnt0_q <= '0;
         gnt_cnt1_q <= '0;
`endif
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         id_q     <= id_d;
         we_q     <= we_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         ram_e_q  <= ram_e_d;
         ram_w_q  <= ram_w_d;
         ram_r_q  <= ram_r_d;
         ack0_q   <= ack0_d;
         ack1_q   <= ack1_d;
         rdata0_q <= rdata0_d;
         rdata1_q <= rdata1_d;
         busy_q   <= busy_d;
`ifdef RAMCTL_STATS_EN
         gnt_cnt0_q <= gnt_cnt0_d;
         gnt_cnt1_q <= gnt_cnt1_d;
`endif
      end
   end

   // Latched address/data registers drive the RAM pins directly.
   assign ram_addr = addr_q;
   assign ram_din  = wdata_q;
   assign ram_e    = ram_e_q;
   assign ram_w    = ram_w_q;
   assign ram_r    = ram_r_q;
   assign ack0     = ack0_q;
   assign ack1     = ack1_q;
   assign rdata0   = rdata0_q;
   assign rdata1   = rdata1_q;
   assign busy     = busy_q;
`ifdef RAMCTL_STATS_EN
   assign gnt_cnt0 = gnt_cnt0_q;
   assign gnt_cnt1 = gnt_cnt1_q;
`endif

endmodule

// File: tb/tb_ram4k_rr_ctrl.sv
// Directed bench for ram4k_rr_ctrl with a behavioural RAM4K model.
module tb_ram4k_rr_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [11:0] addr0 = '0, addr1 = '0;
   logic [15:0] wdata0 = '0, wdata1 = '0;
   logic        ack0, ack1, busy, ram_e, ram_w, ram_r;
   logic [15:0] rdata0, rdata1, ram_din, ram_dout;
   logic [11:0] ram_addr;
`ifdef RAMCTL_STATS_EN
   logic [15:0] gnt_cnt0, gnt_cnt1;
`endif

   int unsigned n_chk = 0;
   int unsigned n_fail = 0;
   logic [15:0] exp_rd [2];
   logic [15:0] mem [0:4095];

   always #5 clk = ~clk;

   ram4k_rr_ctrl #(.AW(12), .DW(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
      .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
      .busy(busy), .ram_e(ram_e), .ram_addr(ram_addr), .ram_din(ram_din),
      .ram_w(ram_w), .ram_r(ram_r), .ram_dout(ram_dout)
`ifdef RAMCTL_STATS_EN
      , .gnt_cnt0(gnt_cnt0), .gnt_cnt1(gnt_cnt1)
`endif
   );

   always @(posedge clk) if (ram_e && ram_w) mem[ram_addr] <= ram_din;
   assign ram_dout = mem[ram_addr];

   typedef struct {
      logic        port;
      logic        we;
      logic [11:0] addr;
      logic [15:0] wdata;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_reset();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      tick();
   endtask

   // Called in an IDLE cycle; returns in the following IDLE cycle.
   task automatic do_txn(input logic port, input logic we, input logic [11:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp);
      bit got = 0;
      bit other = 0;
      int cyc = -1;
      if (port) begin req1 = 1; we1 = we; addr1 = addr; wdata1 = wd; end
      else      begin req0 = 1; we0 = we; addr0 = addr; wdata0 = wd; end
      tick();
      chk("a1_ram_e", ram_e, 1);
      chk("a1_ram_w", ram_w, we);
      chk("a1_ram_r", ram_r, !we);
      chk("a1_ram_addr", ram_addr, addr);
      if (we) chk("a1_ram_din", ram_din, wd);
      chk("a1_busy", busy, 1);
      for (int i = 0; i < 10 && !got; i++) begin
         if (port ? ack0 : ack1) other = 1;
         if (port ? ack1 : ack0) begin got = 1; cyc = i; end
         else tick();
      end
      chk("ack_seen", got, 1);
      chk("ack_latency", cyc, 2);
      chk("other_ack_quiet", other, 0);
      chk("resp_ram_e", ram_e, 0);
      if (port) req1 = 0; else req0 = 0;
      if (!we) exp_rd[port] = exp;
      chk("rdata0", rdata0, exp_rd[0]);
      chk("rdata1", rdata1, exp_rd[1]);
      tick();
      chk("ack_pulse_end", {ack1, ack0}, 2'b00);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1);
   end

   initial begin
      int t0, t1, k, idle_cnt;
      bit got;
      for (int i = 0; i < 4096; i++) mem[i] = '0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      vecs[0] = '{0, 1, 12'h123, 16'hBEEF, 16'h0000};
      vecs[1] = '{0, 0, 12'h123, 16'h0000, 16'hBEEF};
      vecs[2] = '{1, 1, 12'hFFF, 16'hA5A5, 16'h0000};
      vecs[3] = '{1, 0, 12'hFFF, 16'h0000, 16'hA5A5};
      vecs[4] = '{1, 1, 12'h000, 16'h1234, 16'h0000};
      vecs[5] = '{0, 0, 12'h000, 16'h0000, 16'h1234};
      vecs[6] = '{0, 1, 12'h7FF, 16'h0F0F, 16'h0000};
      vecs[7] = '{1, 0, 12'h7FF, 16'h0000, 16'h0F0F};

      // Reset with random inputs
      for (int i = 0; i < 4; i++) begin
         req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
         addr0 = 12'($urandom); addr1 = 12'($urandom);
         wdata0 = 16'($urandom); wdata1 = 16'($urandom);
         tick();
         chk("rst_outs", {ack0, ack1, busy, ram_e, ram_w, ram_r}, 6'b0);
         chk("rst_data", {rdata0, rdata1, ram_din, 4'h0, ram_addr}, 64'h0);
      end
      req0 = 0; req1 = 0; we0 = 0; we1 = 0;
      rst_n = 1'b1;
      tick();
      tick();
      chk("post_rst_idle", {ack0, ack1, busy}, 3'b000);

      foreach (vecs[i]) do_txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp);

      // Simultaneous requests after reset: port 0 first, port 1 four cycles later
      pulse_reset();
      req0 = 1; we0 = 0; addr0 = 12'h000;
      req1 = 1; we1 = 1; addr1 = 12'hFFF; wdata1 = 16'hA5A5;
      t0 = -1; t1 = -1;
      for (int i = 1; i <= 20 && t1 < 0; i++) begin
         tick();
         if (ack0) begin t0 = i; req0 = 0; end
         if (ack1) begin t1 = i; req1 = 0; end
      end
      req0 = 0; req1 = 0;
      chk("tie_ack0_cycle", t0, 3);
      chk("tie_ack1_cycle", t1, 7);
      exp_rd[0] = 16'h1234;
      chk("tie_rdata0", rdata0, exp_rd[0]);
      tick();
      do_txn(1, 0, 12'hFFF, 16'h0000, 16'hA5A5);

      // Both held: strict alternation, one idle cycle between transactions
      req0 = 1; we0 = 0; addr0 = 12'h123;
      req1 = 1; we1 = 0; addr1 = 12'hFFF;
      k = 0; idle_cnt = 0;
      for (int i = 0; i < 60 && k < 8; i++) begin
         tick();
         if (!busy) idle_cnt++;
         if (ack0 | ack1) begin
            chk("rr_order", {ack1, ack0}, (k % 2) ? 2'b10 : 2'b01);
            if (k > 0) chk("rr_idle_gap", idle_cnt, 1);
            idle_cnt = 0;
            k++;
            if (k == 8) begin req0 = 0; req1 = 0; end
         end
      end
      req0 = 0; req1 = 0;
      chk("rr_count", k, 8);
      exp_rd[0] = 16'hBEEF;
      exp_rd[1] = 16'hA5A5;
      chk("rr_rdata0", rdata0, exp_rd[0]);
      chk("rr_rdata1", rdata1, exp_rd[1]);
      tick();

      // Reset during A1: interrupted write is dropped
      do_txn(1, 1, 12'h040, 16'h1111, 16'h0000);
      req1 = 1; we1 = 1; addr1 = 12'h040; wdata1 = 16'h2222;
      tick();
      rst_n = 1'b0; req1 = 0;
      #1;
      chk("rst_a1_clear", {ack1, busy, ram_e, ram_w}, 4'b0);
      tick();
      chk("rst_a1_noack", ack1, 0);
      rst_n = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      tick();
      chk("rst_a1_noack2", {ack0, ack1, busy}, 3'b000);
      do_txn(1, 0, 12'h040, 16'h0000, 16'h1111);

      // Reset during A2: interrupted write already committed
      req1 = 1; we1 = 1; addr1 = 12'h040; wdata1 = 16'h2222;
      tick();
      tick();
      rst_n = 1'b0; req1 = 0;
      #1;
      chk("rst_a2_clear", {ack1, busy, ram_e, ram_w}, 4'b0);
      tick();
      rst_n = 1'b1;
      exp_rd[0] = '0; exp_rd[1] = '0;
      tick();
      chk("rst_a2_noack", {ack0, ack1, busy}, 3'b000);
      do_txn(1, 0, 12'h040, 16'h0000, 16'h2222);

`ifdef RAMCTL_STATS_EN
      pulse_reset();
      do_txn(0, 0, 12'h123, 16'h0000, 16'hBEEF);
      do_txn(1, 0, 12'hFFF, 16'h0000, 16'hA5A5);
      do_txn(0, 0, 12'h123, 16'h0000, 16'hBEEF);
      do_txn(1, 0, 12'hFFF, 16'h0000, 16'hA5A5);
      do_txn(0, 0, 12'h123, 16'h0000, 16'hBEEF);
      chk("gnt_cnt0", gnt_cnt0, 16'd3);
      chk("gnt_cnt1", gnt_cnt1, 16'd2);
      force dut.gnt_cnt0_q = 16'hFFFF;
      #1;
      release dut.gnt_cnt0_q;
      do_txn(0, 0, 12'h123, 16'h0000, 16'hBEEF);
      chk("gnt_cnt0_wrap", gnt_cnt0, 16'h0000);
`endif

      got = (n_fail == 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
